alu_share_sched: RTL and testbench

//  Schedules a single shared ALU among NREQ requesters, granting round-robin.

---
 rtl/alu_share_sched.sv | 164 ++++++++++++++++
 tb/tb_alu_share_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler for one shared ALU with idle clock gating.
// Every output is registered; the idle, wake and wait counts share one counter that restarts on each state change.
module alu_share_sched #(
    parameter int NREQ     = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int BUSY_TO  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_start,
    input  logic                 alu_busy,
    input  logic [15:0]          alu_result,
    output logic                 diss_clk
);
    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = IDLE_CYC > WAKE_CYC ? (IDLE_CYC > BUSY_TO ? IDLE_CYC : BUSY_TO)
                                              : (WAKE_CYC > BUSY_TO ? WAKE_CYC : BUSY_TO);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SLEEP, WAKE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   ptr, ptr_d, gidx, gidx_d, pick;
    logic            pick_ok;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] gnt_d, rsp_valid_d;
    logic [15:0]     rsp_result_d, alu_a_d, alu_b_d;
    logic [3:0]      alu_opcode_d;
    logic            rsp_err_d, alu_start_d, diss_clk_d;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        return IW'(j >= NREQ ? j - NREQ : j);
    endfunction

    // Scan from the farthest slot down so the nearest set bit at/after ptr wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_idx(ptr, k)]) begin
                pick    = rr_idx(ptr, k);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        gidx_d       = gidx;
        cnt_d        = cnt + CW'(1);
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result;
        rsp_err_d    = 1'b0;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_opcode_d = alu_opcode;
        alu_start_d  = 1'b0;
        diss_clk_d   = diss_clk;
        case (state)
            IDLE, SLEEP: begin
                if (pick_ok) begin
                    gidx_d       = pick;
                    gnt_d        = NREQ'(1) << pick;
                    alu_a_d      = req_a[16*pick +: 16];
                    alu_b_d      = req_b[16*pick +: 16];
                    alu_opcode_d = req_op[4*pick +: 4];
                    ptr_d        = pick == IW'(NREQ - 1) ? '0 : pick + IW'(1);
                    cnt_d        = '0;
                    diss_clk_d   = 1'b0;
                    state_d      = state == SLEEP ? WAKE : ISSUE;
                end else if (state == SLEEP) begin
                    cnt_d = '0;
                end else if (cnt == CW'(IDLE_CYC - 1)) begin
                    cnt_d      = '0;
                    diss_clk_d = 1'b1;
                    state_d    = SLEEP;
                end
            end
            // The last wake cycle issues the start itself so alu_start lands WAKE_CYC after wake-up.
            WAKE: begin
                if (cnt == CW'(WAKE_CYC - 1)) begin
                    cnt_d       = '0;
                    alu_start_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            ISSUE: begin
                cnt_d       = '0;
                alu_start_d = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (cnt != '0 && !alu_busy) begin
                    cnt_d        = '0;
                    rsp_result_d = alu_result;
                    rsp_valid_d  = NREQ'(1) << gidx;
                    state_d      = RESP;
                end else if (cnt == CW'(BUSY_TO - 1)) begin
                    cnt_d        = '0;
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    rsp_valid_d  = NREQ'(1) << gidx;
                    state_d      = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            cnt        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_start  <= 1'b0;
            diss_clk   <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            gidx       <= gidx_d;
            cnt        <= cnt_d;
            gnt        <= gnt_d;
            rsp_valid  <= rsp_valid_d;
            rsp_result <= rsp_result_d;
            rsp_err    <= rsp_err_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_opcode <= alu_opcode_d;
            alu_start  <= alu_start_d;
            diss_clk   <= diss_clk_d;
        end
    end
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: directed checks of grant order, sequencing, sleep/wake, timeout and reset abort.
module tb_alu_share_sched;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_a, req_b;
    logic [4*NREQ-1:0]    req_op;
    logic [NREQ-1:0]      gnt, rsp_valid;
    logic [15:0]          rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]           alu_opcode;
    logic                 rsp_err, alu_start, alu_busy, diss_clk;
    logic                 hang;
    int                   blen;
    int                   bcnt;
    int                   ntest = 0;
    int                   nfail = 0;

    alu_share_sched #(.NREQ(NREQ), .IDLE_CYC(16), .WAKE_CYC(2), .BUSY_TO(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_busy(alu_busy), .alu_result(alu_result), .diss_clk(diss_clk)
    );

    always #5 clk = ~clk;

    // ALU model: 0=ADD 1=SUB else AND; busy for blen cycles after start, or forever when hang
    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else if (alu_start) bcnt <= blen;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign alu_busy   = hang || (bcnt != 0);
    assign alu_result = alu_opcode == 4'd0 ? alu_a + alu_b :
                        alu_opcode == 4'd1 ? alu_a - alu_b : alu_a & alu_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntest++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_op[4*i +: 4]  = op;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (gnt == '0 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_res [4];
        exp_res = '{16'h0100, 16'h0111, 16'h0122, 16'h0133};
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0; hang = 1'b0; blen = 0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_start", 32'(alu_start), 0);
        chk("rst_diss_clk", 32'(diss_clk), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        rst = 1'b0;
        // single ADD at minimum latency
        set_slot(0, 16'd3, 16'd4, 4'd0);
        req = 4'b0001;
        step();
        chk("t1_gnt", 32'(gnt), 32'b0001);
        chk("t1_alu_a", 32'(alu_a), 3);
        chk("t1_alu_b", 32'(alu_b), 4);
        chk("t1_start_early", 32'(alu_start), 0);
        req = '0;
        step();
        chk("t1_gnt_pulse", 32'(gnt), 0);
        chk("t1_start", 32'(alu_start), 1);
        step();
        chk("t1_start_pulse", 32'(alu_start), 0);
        chk("t1_rsp_early", 32'(rsp_valid), 0);
        step();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t1_rsp_result", 32'(rsp_result), 7);
        chk("t1_rsp_err", 32'(rsp_err), 0);
        step();
        chk("t1_rsp_pulse", 32'(rsp_valid), 0);
        // operands change after grant
        blen = 3;
        set_slot(0, 16'd10, 16'd5, 4'd1);
        req = 4'b0001;
        step();
        chk("t6_gnt", 32'(gnt), 32'b0001);
        chk("t6_alu_a_grant", 32'(alu_a), 10);
        set_slot(0, 16'd99, 16'd5, 4'd1);
        req = '0;
        step();
        chk("t6_alu_a_held", 32'(alu_a), 10);
        wait_rsp("t6_rsp_wait");
        chk("t6_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t6_rsp_result", 32'(rsp_result), 5);
        // round-robin with all requesters held
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_slot(i, 16'h0100 + 16'(i * 16'h10), 16'(i), 4'd0);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_gnt("t2_gnt_wait");
            chk("t2_gnt", 32'(gnt), 32'(1 << (k % 4)));
            wait_rsp("t2_rsp_wait");
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(1 << (k % 4)));
            chk("t2_rsp_result", 32'(rsp_result), 32'(exp_res[k % 4]));
        end
        req = '0;
        // idle gating and wake
        step();
        repeat (15) step();
        chk("t3_diss_before", 32'(diss_clk), 0);
        step();
        chk("t3_diss_on", 32'(diss_clk), 1);
        repeat (3) step();
        chk("t3_diss_hold", 32'(diss_clk), 1);
        set_slot(2, 16'hF0F0, 16'h0FF0, 4'd2);
        req = 4'b0100;
        step();
        chk("t3_diss_off", 32'(diss_clk), 0);
        chk("t3_gnt", 32'(gnt), 32'b0100);
        chk("t3_start_early0", 32'(alu_start), 0);
        req = '0;
        step();
        chk("t3_start_early1", 32'(alu_start), 0);
        step();
        chk("t3_start", 32'(alu_start), 1);
        wait_rsp("t3_rsp_wait");
        chk("t3_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("t3_rsp_result", 32'(rsp_result), 16'h00F0);
        // busy timeout
        hang = 1'b1;
        set_slot(1, 16'd1, 16'd1, 4'd0);
        req = 4'b0010;
        wait_gnt("t4_gnt_wait");
        chk("t4_gnt", 32'(gnt), 32'b0010);
        req = '0;
        step();
        chk("t4_start", 32'(alu_start), 1);
        repeat (63) step();
        chk("t4_rsp_early", 32'(rsp_valid), 0);
        chk("t4_diss_busy", 32'(diss_clk), 0);
        step();
        chk("t4_rsp_valid", 32'(rsp_valid), 32'b0010);
        chk("t4_rsp_err", 32'(rsp_err), 1);
        chk("t4_rsp_result", 32'(rsp_result), 0);
        hang = 1'b0;
        set_slot(0, 16'd2, 16'd3, 4'd0);
        req = 4'b0001;
        wait_gnt("t4b_gnt_wait");
        chk("t4b_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wait_rsp("t4b_rsp_wait");
        chk("t4b_rsp_result", 32'(rsp_result), 5);
        chk("t4b_rsp_err", 32'(rsp_err), 0);
        // reset during WAIT
        blen = 10;
        set_slot(0, 16'd7, 16'd8, 4'd0);
        set_slot(1, 16'h1234, 16'd1, 4'd0);
        req = 4'b1111;
        wait_gnt("t5_gnt_wait");
        chk("t5_gnt", 32'(gnt), 32'b0010);
        step();
        chk("t5_start", 32'(alu_start), 1);
        step();
        step();
        chk("t5_alu_a", 32'(alu_a), 16'h1234);
        rst = 1'b1;
        #1;
        chk("t5_rst_alu_a", 32'(alu_a), 0);
        chk("t5_rst_result", 32'(rsp_result), 0);
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_start", 32'(alu_start), 0);
        step();
        step();
        chk("t5_rst_rsp", 32'(rsp_valid), 0);
        rst = 1'b0;
        wait_gnt("t5b_gnt_wait");
        chk("t5b_gnt", 32'(gnt), 32'b0001);
        req = '0;
        wait_rsp("t5b_rsp_wait");
        chk("t5b_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t5b_rsp_result", 32'(rsp_result), 15);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
